// File: rtl/wishbone_master_controller.sv
// Wishbone B4 classic single-transfer initiator: one bus cycle per local command.
// Optional REQ-phase abort timer enabled by defining WB_MASTER_TIMEOUT_EN.
module wishbone_master_controller #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [3:0]  cmd_sel,
  output logic        cmd_ready,
  output logic        cmd_done,
  output logic        cmd_error,
  output logic [31:0] cmd_rdata,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        ready_q, ready_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef WB_MASTER_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_op != 2'b00) begin
          adr_d   = BASE_ADDR + (cmd_addr & 32'hFFFF_FFFC);
          dat_d   = cmd_data;
          sel_d   = cmd_sel;
          we_d    = (cmd_op == 2'b11);
          ready_d = 1'b0;
          if (cmd_op == 2'b10) begin
            // illegal op completes immediately without touching the bus
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_REQ;
            cyc_d   = 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ST_REQ: begin
        if (wbm_err_i) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
          if (!we_q) rdata_d = '0;
        end else if (wbm_ack_i) begin
          cyc_d   = 1'b0;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
          if (!we_q) rdata_d = wbm_dat_i;
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
          if (!we_q) rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        err_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        cyc_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign cmd_ready = ready_q;
  assign cmd_done  = done_q;
  assign cmd_error = err_q;
  assign cmd_rdata = rdata_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wishbone_master_controller.sv
// Bench for wishbone_master_controller: directed vector table, randomized
// transactions against a transaction-level model, long wait and mid-cycle reset.
module tb_wishbone_master_controller;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_sel;
  logic        cmd_ready, cmd_done, cmd_error;
  logic [31:0] cmd_rdata;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata;

  wishbone_master_controller dut (
    .clk(clk), .reset(reset),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_sel(cmd_sel),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done), .cmd_error(cmd_error), .cmd_rdata(cmd_rdata),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    int          dly;
    logic        ack;
    logic        err;
    logic [31:0] dati;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic run(input vec_t v);
    logic [31:0] exp_adr;
    exp_adr = BASE + {v.addr[31:2], 2'b00};
    chk("ready_before", {31'd0, cmd_ready}, 32'd1);
    cmd_op = v.op; cmd_addr = v.addr; cmd_data = v.data; cmd_sel = v.sel;
    @(posedge clk); #1;
    cmd_op = 2'b00;
    chk("ready_busy", {31'd0, cmd_ready}, 32'd0);
    if (v.op == 2'b10) begin
      chk("illegal_cyc", {31'd0, wbm_cyc_o}, 32'd0);
      chk("illegal_done", {31'd0, cmd_done}, 32'd1);
      chk("illegal_err", {31'd0, cmd_error}, 32'd1);
    end else begin
      for (int i = 0; i <= v.dly; i++) begin
        chk("cyc_high", {31'd0, wbm_cyc_o}, 32'd1);
        chk("stb_eq_cyc", {31'd0, wbm_stb_o}, {31'd0, wbm_cyc_o});
        chk("adr", wbm_adr_o, exp_adr);
        chk("we", {31'd0, wbm_we_o}, {31'd0, v.op == 2'b11});
        chk("sel", {28'd0, wbm_sel_o}, {28'd0, v.sel});
        if (v.op == 2'b11) chk("dat_o", wbm_dat_o, v.data);
        chk("done_early", {31'd0, cmd_done}, 32'd0);
        if (i < v.dly) begin
          // a command offered while busy must be ignored
          cmd_op = 2'b11; cmd_addr = ~v.addr;
          @(posedge clk); #1;
          cmd_op = 2'b00;
        end
      end
      wbm_ack_i = v.ack; wbm_err_i = v.err; wbm_dat_i = v.dati;
      @(posedge clk); #1;
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
      chk("cyc_drop", {31'd0, wbm_cyc_o}, 32'd0);
      chk("done", {31'd0, cmd_done}, 32'd1);
      chk("error", {31'd0, cmd_error}, {31'd0, v.exp_err});
    end
    chk("rdata", cmd_rdata, v.exp_rdata);
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, cmd_done}, 32'd0);
    chk("err_clear", {31'd0, cmd_error}, 32'd0);
    chk("ready_back", {31'd0, cmd_ready}, 32'd1);
    chk("cyc_gap", {31'd0, wbm_cyc_o}, 32'd0);
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    reset = 1'b1; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0; cmd_sel = '0;
    wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
    chk("rst_we", {31'd0, wbm_we_o}, 32'd0);
    chk("rst_sel", {28'd0, wbm_sel_o}, 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_dat", wbm_dat_o, 32'd0);
    chk("rst_done", {31'd0, cmd_done}, 32'd0);
    chk("rst_err", {31'd0, cmd_error}, 32'd0);
    chk("rst_rdata", cmd_rdata, 32'd0);

    //        op     addr          data          sel   dly ack  err  dati          exp_err rdata
    tbl[0] = '{2'b11, 32'h0,        32'h3,        4'hF, 2, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[1] = '{2'b01, 32'h4,        32'h0,        4'hF, 0, 1'b1, 1'b0, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001};
    tbl[2] = '{2'b11, 32'h13,       32'h55,       4'h3, 1, 1'b1, 1'b0, 32'h1111_2222, 1'b0, 32'hCAFE_0001};
    tbl[3] = '{2'b01, 32'h8,        32'h0,        4'hF, 1, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 32'h0};
    tbl[4] = '{2'b01, 32'hFFFF_FFF7, 32'h0,       4'h1, 0, 1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5};
    tbl[5] = '{2'b11, 32'h20,       32'hDEAD_BEEF, 4'hC, 3, 1'b0, 1'b1, 32'h0,        1'b1, 32'hA5A5_A5A5};
    tbl[6] = '{2'b10, 32'h24,       32'h0,        4'hF, 0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA5A5_A5A5};
    tbl[7] = '{2'b01, 32'h28,       32'h0,        4'hF, 0, 1'b0, 1'b1, 32'h7777_7777, 1'b1, 32'h0};
    for (int i = 0; i < 8; i++) run(tbl[i]);

    // Randomized transactions: expected error and read-data follow the command-level rules.
    model_rdata = 32'h0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: rv.op = 2'b01;
        1: rv.op = 2'b11;
        default: rv.op = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01;
      endcase
      rv.addr = $urandom; rv.data = $urandom; rv.sel = 4'($urandom);
      rv.dly  = int'($urandom_range(0, 4));
      rv.err  = ($urandom_range(0, 4) == 0);
      rv.ack  = rv.err ? 1'($urandom) : 1'b1;
      rv.dati = $urandom;
      rv.exp_err = (rv.op == 2'b10) || rv.err;
      if (rv.op == 2'b01) model_rdata = rv.err ? 32'h0 : rv.dati;
      rv.exp_rdata = model_rdata;
      run(rv);
    end

    // No timeout in this build: the cycle stays open until the responder answers.
    cmd_op = 2'b01; cmd_addr = 32'h40; cmd_sel = 4'hF;
    @(posedge clk); #1 cmd_op = 2'b00;
    repeat (300) @(posedge clk);
    #1;
    chk("long_wait_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    chk("long_wait_done", {31'd0, cmd_done}, 32'd0);
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h0BAD_F00D;
    @(posedge clk); #1 wbm_ack_i = 1'b0;
    chk("long_wait_rdata", cmd_rdata, 32'h0BAD_F00D);
    chk("long_wait_done2", {31'd0, cmd_done}, 32'd1);
    @(posedge clk); #1;

    // Reset in the middle of a bus cycle, then a stray acknowledge afterwards.
    cmd_op = 2'b11; cmd_addr = 32'h50; cmd_data = 32'h1; cmd_sel = 4'hF;
    @(posedge clk); #1 cmd_op = 2'b00;
    @(posedge clk); #1;
    chk("pre_rst_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("midrst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("midrst_stb", {31'd0, wbm_stb_o}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_done", {31'd0, cmd_done}, 32'd0);
    wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_dat_i = 32'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("late_ack_done", {31'd0, cmd_done}, 32'd0);
      chk("late_ack_err", {31'd0, cmd_error}, 32'd0);
      chk("late_ack_rdata", cmd_rdata, 32'h0);
      chk("late_ack_ready", {31'd0, cmd_ready}, 32'd1);
    end
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    @(posedge clk); #1;
    run('{2'b01, 32'h60, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'h600D_0001, 1'b0, 32'h600D_0001});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
